spcpu_mem_bridge: RTL and testbench

//  Downstream of spcpu: converts the CPU's 16-bit/8-bit data-bus requests into

---
 rtl/pkg_cpu.sv | 8 +
 rtl/spcpu_mem_bridge_pkg.sv | 26 ++
 rtl/spcpu_mem_bridge.sv | 141 ++++++++++++++
 tb/tb_spcpu_mem_bridge.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pkg_cpu.sv
// Shared CPU bus definitions used by spcpu and the blocks hanging off its data bus.
package pkg_cpu;

  // Data-bus access size encoding on the acc_sz line.
  localparam logic cpu_data_acc_sz_8  = 1'b0;
  localparam logic cpu_data_acc_sz_16 = 1'b1;

endpackage

// File: rtl/spcpu_mem_bridge_pkg.sv
// Types and byte-lane helpers for the CPU-to-byte-SRAM bridge.
package pkg_mem_bridge;

  typedef enum logic [1:0] {
    mb_st_idle,
    mb_st_b0,
    mb_st_b1,
    mb_st_fin
  } mb_state;

  // Pick the byte of a 16-bit word that goes to the first (second=0) or
  // second (second=1) byte address. Big-endian puts [15:8] at the lower address.
  function automatic logic [7:0] mb_lane(input logic [15:0] d,
                                         input logic        second,
                                         input logic        big_endian);
    mb_lane = (second ^ big_endian) ? d[15:8] : d[7:0];
  endfunction

  // Rebuild a 16-bit word from the bytes read at addr (b0) and addr+1 (b1).
  function automatic logic [15:0] mb_word(input logic [7:0] b0,
                                          input logic [7:0] b1,
                                          input logic       big_endian);
    mb_word = big_endian ? {b0, b1} : {b1, b0};
  endfunction

endpackage

// File: rtl/spcpu_mem_bridge.sv
// Converts spcpu 8/16-bit data-bus requests into byte-wide synchronous SRAM
// cycles; all outputs are registered.
module spcpu_mem_bridge
  import pkg_mem_bridge::*;
  import pkg_cpu::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  acc_sz,
  input  logic                  we,
  input  logic [15:0]           wdata,
  output logic [15:0]           rdata,
  output logic                  ready,
  output logic                  busy,
  output logic                  overrun,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  mb_state               state, state_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic                  sz_q, sz_d;
  logic                  we_q, we_d;
  logic [15:0]           wd_q, wd_d;
  logic [7:0]            b0_q, b0_d;
  logic [15:0]           rdata_d;
  logic                  ready_d, busy_d, overrun_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic                  mem_en_d, mem_we_d;
  logic [7:0]            mem_wdata_d;

  // State and output registers; reset drops everything so an aborted access
  // can never produce a ready or another SRAM enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= mb_st_idle;
      a_q       <= '0;
      sz_q      <= 1'b0;
      we_q      <= 1'b0;
      wd_q      <= '0;
      b0_q      <= '0;
      rdata     <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      mem_addr  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      a_q       <= a_d;
      sz_q      <= sz_d;
      we_q      <= we_d;
      wd_q      <= wd_d;
      b0_q      <= b0_d;
      rdata     <= rdata_d;
      ready     <= ready_d;
      busy      <= busy_d;
      overrun   <= overrun_d;
      mem_addr  <= mem_addr_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_wdata <= mem_wdata_d;
    end
  end

  // Next-state and next-output logic: each state sets up the SRAM cycle that
  // the memory will sample on the following edge.
  always_comb begin
    state_d     = state;
    a_d         = a_q;
    sz_d        = sz_q;
    we_d        = we_q;
    wd_d        = wd_q;
    b0_d        = b0_q;
    rdata_d     = rdata;
    ready_d     = 1'b0;
    mem_addr_d  = mem_addr;
    mem_en_d    = mem_en;
    mem_we_d    = mem_we;
    mem_wdata_d = mem_wdata;
    // A request is only meaningful in idle; anything else is a CPU protocol slip.
    overrun_d   = overrun | (req & (state != mb_st_idle));

    unique case (state)
      mb_st_idle: begin
        if (req) begin
          a_d         = addr;
          sz_d        = acc_sz;
          we_d        = we;
          wd_d        = wdata;
          mem_en_d    = 1'b1;
          mem_we_d    = we;
          mem_addr_d  = addr;
          mem_wdata_d = (acc_sz == cpu_data_acc_sz_16) ?
                        mb_lane(wdata, 1'b0, BIG_ENDIAN) : wdata[7:0];
          state_d     = mb_st_b0;
        end
      end
      mb_st_b0: begin
        if (sz_q == cpu_data_acc_sz_16) begin
          // Address simply wraps at the top of the byte space.
          mem_addr_d  = a_q + ADDR_WIDTH'(1);
          mem_wdata_d = mb_lane(wd_q, 1'b1, BIG_ENDIAN);
          state_d     = mb_st_b1;
        end else begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = mb_st_fin;
        end
      end
      mb_st_b1: begin
        // First byte's read data arrives while the second byte is sampled.
        b0_d     = mem_rdata;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        state_d  = mb_st_fin;
      end
      mb_st_fin: begin
        if (!we_q)
          rdata_d = (sz_q == cpu_data_acc_sz_16) ?
                    mb_word(b0_q, mem_rdata, BIG_ENDIAN) : {8'h00, mem_rdata};
        ready_d = 1'b1;
        state_d = mb_st_idle;
      end
      default: state_d = mb_st_idle;
    endcase

    busy_d = (state_d != mb_st_idle);
  end

endmodule

// File: tb/tb_spcpu_mem_bridge.sv
// Self-checking bench: big- and little-endian bridges driven in lockstep, each
// with its own 64 KiB registered-read SRAM, checked against a byte-array model.
module tb_spcpu_mem_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [15:0] addr = '0;
  logic        acc_sz = 1'b0;
  logic        we = 1'b0;
  logic [15:0] wdata = '0;

  logic [15:0] rdata0, rdata1;
  logic        ready0, ready1, busy0, busy1, overrun0, overrun1;
  logic [15:0] mem_addr0, mem_addr1;
  logic        mem_en0, mem_en1, mem_we0, mem_we1;
  logic [7:0]  mem_wdata0, mem_wdata1;
  logic [7:0]  mem_rdata0 = '0, mem_rdata1 = '0;

  logic [7:0] mem0 [0:65535];
  logic [7:0] mem1 [0:65535];
  logic [7:0] ref0 [0:65535];
  logic [7:0] ref1 [0:65535];

  int errors = 0;
  int checks = 0;
  int en_cnt = 0;
  logic [15:0] exp_rd0 = '0, exp_rd1 = '0;

  always #5 clk = ~clk;

  spcpu_mem_bridge #(.ADDR_WIDTH(16), .BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .acc_sz(acc_sz),
    .we(we), .wdata(wdata), .rdata(rdata0), .ready(ready0), .busy(busy0),
    .overrun(overrun0), .mem_addr(mem_addr0), .mem_en(mem_en0),
    .mem_we(mem_we0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0));

  spcpu_mem_bridge #(.ADDR_WIDTH(16), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .acc_sz(acc_sz),
    .we(we), .wdata(wdata), .rdata(rdata1), .ready(ready1), .busy(busy1),
    .overrun(overrun1), .mem_addr(mem_addr1), .mem_en(mem_en1),
    .mem_we(mem_we1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1));

  // Synchronous SRAMs: write or registered read on each enabled edge.
  always @(posedge clk) begin
    if (mem_en0) begin
      if (mem_we0) mem0[mem_addr0] <= mem_wdata0;
      else         mem_rdata0 <= mem0[mem_addr0];
    end
    if (mem_en1) begin
      if (mem_we1) mem1[mem_addr1] <= mem_wdata1;
      else         mem_rdata1 <= mem1[mem_addr1];
    end
  end

  // Count edges at which the big-endian SRAM is enabled.
  always @(posedge clk) if (mem_en0) en_cnt = en_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: memory as a plain byte array, words built by endianness rule.
  function automatic logic [15:0] ref_rd(input bit be, input logic s16, input logic [15:0] a);
    logic [15:0] a1;
    logic [7:0]  b0, b1;
    a1 = a + 16'd1;
    b0 = be ? ref0[a]  : ref1[a];
    b1 = be ? ref0[a1] : ref1[a1];
    if (!s16) return {8'h00, b0};
    return be ? {b0, b1} : {b1, b0};
  endfunction

  task automatic ref_wr(input logic s16, input logic [15:0] a, input logic [15:0] d);
    logic [15:0] a1;
    a1 = a + 16'd1;
    if (!s16) begin
      ref0[a] = d[7:0];
      ref1[a] = d[7:0];
    end else begin
      ref0[a] = d[15:8]; ref0[a1] = d[7:0];
      ref1[a] = d[7:0];  ref1[a1] = d[15:8];
    end
  endtask

  task automatic set_byte(input logic [15:0] a, input logic [7:0] v);
    mem0[a] = v; mem1[a] = v; ref0[a] = v; ref1[a] = v;
  endtask

  // One access started at the current time (just after an edge); dup keeps
  // req high an extra cycle so it lands while busy.
  task automatic access(input string tag, input logic w, input logic s16,
                        input logic [15:0] a, input logic [15:0] d, input bit dup);
    int n;
    req = 1'b1; we = w; acc_sz = s16; addr = a; wdata = d; en_cnt = 0;
    @(posedge clk); #1; n = 1; req = dup;
    chk({tag, ".busy"}, busy0, 1'b1);
    chk({tag, ".rdy_low"}, ready0, 1'b0);
    if (dup) begin @(posedge clk); #1; n++; req = 1'b0; end
    while (!ready0 && n < 20) begin @(posedge clk); #1; n++; end
    if (w) ref_wr(s16, a, d);
    else begin
      exp_rd0 = ref_rd(1'b1, s16, a);
      exp_rd1 = ref_rd(1'b0, s16, a);
    end
    chk({tag, ".lat"}, n, s16 ? 4 : 3);
    chk({tag, ".rdy_le"}, ready1, 1'b1);
    chk({tag, ".rd_be"}, rdata0, exp_rd0);
    chk({tag, ".rd_le"}, rdata1, exp_rd1);
    chk({tag, ".en_cnt"}, en_cnt, s16 ? 2 : 1);
  endtask

  initial begin
    int mism;
    int seen;
    logic [15:0] ra;
    for (int i = 0; i < 65536; i++) set_byte(16'(i), 8'($urandom));

    #12;
    chk("rst.rdata", rdata0, 16'h0);
    chk("rst.ready", ready0, 1'b0);
    chk("rst.busy", busy0, 1'b0);
    chk("rst.overrun", overrun0, 1'b0);
    chk("rst.mem_en", mem_en0, 1'b0);
    chk("rst.mem_we", mem_we0, 1'b0);
    chk("rst.mem_addr", mem_addr0, 16'h0);
    chk("rst.mem_wdata", mem_wdata0, 8'h0);
    @(posedge clk); #1; reset = 1'b0;

    // 1: read16 from prepared bytes
    set_byte(16'h0010, 8'hAB); set_byte(16'h0011, 8'hCD);
    access("rd16", 1'b0, 1'b1, 16'h0010, 16'h0, 1'b0);
    chk("rd16.be_const", rdata0, 16'hABCD);
    chk("rd16.le_const", rdata1, 16'hCDAB);

    // 2: read8, zero-extended (back-to-back with the previous ready)
    access("rd8", 1'b0, 1'b0, 16'h0011, 16'h0, 1'b0);
    chk("rd8.const", rdata0, 16'h00CD);

    // 3: write16, rdata untouched
    access("wr16", 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0);
    chk("wr16.m20_be", mem0[16'h0020], 8'h12);
    chk("wr16.m21_be", mem0[16'h0021], 8'h34);
    chk("wr16.m20_le", mem1[16'h0020], 8'h34);
    chk("wr16.m21_le", mem1[16'h0021], 8'h12);
    chk("wr16.rd_hold", rdata0, 16'h00CD);

    // 4: read16 wrapping past the top of memory
    set_byte(16'hFFFF, 8'h5A); set_byte(16'h0000, 8'hA5);
    access("wrap", 1'b0, 1'b1, 16'hFFFF, 16'h0, 1'b0);
    chk("wrap.const", rdata0, 16'h5AA5);

    // 5: reset in B1 of a write16
    @(posedge clk); #1;
    ra = 16'h0040;
    req = 1'b1; we = 1'b1; acc_sz = 1'b1; addr = ra; wdata = 16'hBEEF;
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("arst.mem_en", mem_en0, 1'b0);
    chk("arst.busy", busy0, 1'b0);
    chk("arst.mem_addr", mem_addr0, 16'h0);
    chk("arst.rdata", rdata0, 16'h0);
    exp_rd0 = '0; exp_rd1 = '0;
    ref0[ra] = 8'hBE; ref1[ra] = 8'hEF;   // only byte 0 was sampled
    @(posedge clk); @(posedge clk); #1; reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (ready0 || mem_en0) seen++; end
    chk("arst.quiet", seen, 0);
    chk("arst.m41", mem0[ra + 16'd1], ref0[ra + 16'd1]);
    access("post_rst", 1'b0, 1'b1, ra, 16'h0, 1'b0);

    // 6: req while busy -> overrun, access unaffected
    chk("ovr.before", overrun0, 1'b0);
    access("ovr", 1'b0, 1'b1, 16'h0010, 16'h0, 1'b1);
    chk("ovr.be", overrun0, 1'b1);
    chk("ovr.le", overrun1, 1'b1);

    // Randomized back-to-back traffic, including odd and top-of-memory addresses
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
      access($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom), ra, 16'($urandom), 1'b0);
    end
    chk("sticky", overrun0, 1'b1);

    mism = 0;
    for (int i = 0; i < 65536; i++)
      if (mem0[i] !== ref0[i] || mem1[i] !== ref1[i]) mism++;
    chk("mem_image", mism, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
